// File: rtl/reset_sequencer.sv
// Board-level reset controller: synchronizes PLL lock and the GRESET button, debounces the
// button and stretches every reset into a fixed-length active-high pulse with cause/count status.
module reset_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned HOLD_CYCLES     = 256
) (
    input  logic       io_mainClk,
    input  logic       io_asyncResetn,
    input  logic       io_pllLocked,
    input  logic       io_button,
    output logic       io_systemReset,
    output logic [1:0] io_resetCause,
    output logic [7:0] io_buttonResets
);
    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [1:0] CAUSE_PLL = 2'd1;
    localparam logic [1:0] CAUSE_BTN = 2'd2;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    logic              r_lock_meta;
    logic              r_lock_s;
    logic              r_btn_meta;
    logic              r_btn_s;
    logic              r_btn_db;
    logic              r_btn_db_q;
    logic [DB_W-1:0]   r_db_cnt;
    state_t            r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_sys_rst;
    logic [1:0]        r_cause;
    logic [7:0]        r_btn_resets;

    state_t            w_next_state;
    logic [HOLD_W-1:0] w_hold_cnt_next;
    logic [1:0]        w_cause_next;
    logic [7:0]        w_btn_resets_next;
    logic              w_release;

    // Synchronizers and button debouncer; these run regardless of sequencer state.
    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_btn_meta  <= 1'b0;
            r_btn_s     <= 1'b0;
            r_btn_db    <= 1'b0;
            r_btn_db_q  <= 1'b0;
            r_db_cnt    <= '0;
        end else begin
            r_lock_meta <= io_pllLocked;
            r_lock_s    <= r_lock_meta;
            r_btn_meta  <= io_button;
            r_btn_s     <= r_btn_meta;
            r_btn_db_q  <= r_btn_db;
            if (r_btn_s == r_btn_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                r_btn_db <= r_btn_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    assign w_release = r_btn_db_q & ~r_btn_db;

    // State register plus status flops that move on the same edge as the transition.
    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            r_state      <= ST_WAIT_LOCK;
            r_hold_cnt   <= '0;
            r_sys_rst    <= 1'b1;
            r_cause      <= 2'd0;
            r_btn_resets <= 8'd0;
        end else begin
            r_state      <= w_next_state;
            r_hold_cnt   <= w_hold_cnt_next;
            r_sys_rst    <= (w_next_state != ST_RUN);
            r_cause      <= w_cause_next;
            r_btn_resets <= w_btn_resets_next;
        end
    end

    // Lock loss always wins over a simultaneous button release.
    always_comb begin
        w_next_state      = r_state;
        w_hold_cnt_next   = r_hold_cnt;
        w_cause_next      = r_cause;
        w_btn_resets_next = r_btn_resets;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (r_lock_s) begin
                    w_next_state    = ST_HOLD;
                    w_hold_cnt_next = '0;
                end
            end
            ST_HOLD: begin
                if (!r_lock_s) begin
                    w_next_state = ST_WAIT_LOCK;
                    w_cause_next = CAUSE_PLL;
                end else if (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (!r_lock_s) begin
                    w_next_state = ST_WAIT_LOCK;
                    w_cause_next = CAUSE_PLL;
                end else if (w_release) begin
                    w_next_state    = ST_HOLD;
                    w_hold_cnt_next = '0;
                    w_cause_next    = CAUSE_BTN;
                    if (r_btn_resets != 8'hFF) begin
                        w_btn_resets_next = r_btn_resets + 8'd1;
                    end
                end
            end
            default: begin
                w_next_state = ST_WAIT_LOCK;
            end
        endcase
    end

    assign io_systemReset  = r_sys_rst;
    assign io_resetCause   = r_cause;
    assign io_buttonResets = r_btn_resets;

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Board-level reset controller for the Murax/BlackIce top level. It sits directly upstream of the `MuraxArduino` `io_asyncReset` input and combines three sources into one clean, stretched, active-high system reset: PLL lock status, the GRESET push-button, and the power-on reset. It replaces the ad-hoc reset counter and the edge detector in the top level. It also exposes the last reset cause and a button-reset counter for the CPU to read via GPIO.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 120000: button input must be stable this many cycles before the debounced level changes; must be ≥ 2.
- `HOLD_CYCLES`, 256: length of every reset pulse, in cycles; must be ≥ 1.

Ports:
- `io_mainClk`  in  1  system clock (PLL output).
- `io_asyncResetn`  in  1  asynchronous, active-low reset (power-on).
- `io_pllLocked`  in  1  raw PLL LOCK, asynchronous to `io_mainClk`.
- `io_button`  in  1  raw GRESET pin, active-high while pressed, asynchronous and bouncing.
- `io_systemReset`  out  1  registered, active-high reset to `MuraxArduino.io_asyncReset`.
- `io_resetCause`  out  2  0 = power-on, 1 = PLL loss, 2 = button; 3 is never driven.
- `io_buttonResets`  out  8  count of button-triggered resets, saturating at 255.

## Operation
- **Synchronizers.** Each of `io_pllLocked` and `io_button` passes through its own 2-flop synchronizer; the outputs are `lock_s` and `btn_s`. Both reset to 0.
- **Debouncer.**
  - Holds the register `btn_db` (reset 0) and a counter `db_cnt` of width `$clog2(DEBOUNCE_CYCLES)` (reset 0).
  - When `btn_s == btn_db`: `db_cnt <= 0`.
  - Otherwise, if `db_cnt == DEBOUNCE_CYCLES-1`: `btn_db <= btn_s` and `db_cnt <= 0`.
  - Otherwise: `db_cnt++`.
  - A release event is `btn_db` going 1→0 (a registered previous value is compared).
  - The debouncer runs in every state.
- **FSM.** States WAIT_LOCK, HOLD, RUN; the reset state is WAIT_LOCK.
  - **WAIT_LOCK:** when `lock_s=1`, go to HOLD with `hold_cnt <= 0`.
  - **HOLD:**
    - If `lock_s=0`: go to WAIT_LOCK and set cause = 1.
    - Else if `hold_cnt == HOLD_CYCLES-1`: go to RUN.
    - Else: `hold_cnt++`.
  - **RUN:**
    - If `lock_s=0`: go to WAIT_LOCK and set cause = 1.
    - Else on a release event: go to HOLD, `hold_cnt <= 0`, set cause = 2, and increment `io_buttonResets` unless it is 255.
  - PLL loss has priority over a release event in the same cycle; in that case the counter does not increment.
  - Release events occurring in WAIT_LOCK or HOLD are ignored (no restart, no count).
- **Output.** `io_systemReset` is a flop loaded with (next_state != RUN). It therefore asserts on the same edge as the RUN→HOLD/WAIT_LOCK transition and deasserts on the same edge as the HOLD→RUN transition.
- **Reset values.** `io_systemReset` = 1, `io_resetCause` = 0, `io_buttonResets` = 0, `hold_cnt` = 0.
- **Mid-operation reset.** Asserting `io_asyncResetn` in any state immediately returns all registers to their reset values. Cause returns to 0 and the counter returns to 0.

## Timing
- **Lock latency.** `io_pllLocked` rising is sampled at edge 0; `lock_s`=1 after edge 1; the FSM enters HOLD at edge 2. `io_systemReset` falls at edge 2+HOLD_CYCLES.
- **Button latency.** Release first sampled at edge 0 (button bouncing has ended); `btn_db` falls at edge DEBOUNCE_CYCLES+1. RUN→HOLD and `io_systemReset` rises at edge DEBOUNCE_CYCLES+2. The reset stays high exactly HOLD_CYCLES cycles.
- **PLL loss latency.** `io_pllLocked` falling reaches `lock_s` in 2 edges; `io_systemReset` rises on the 3rd edge.
- **Status timing.** `io_resetCause` and `io_buttonResets` update on the same edge as the state transition.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4 and `HOLD_CYCLES`=8.
- **Power-on:** `io_asyncResetn`=0, then release with `io_pllLocked`=1 held → `io_systemReset`=1 through edge 9 and 0 after edge 10; cause=0; count=0.
- **Bounce rejection:** in RUN, `io_button` high for 3 cycles then low → no `io_systemReset` pulse, count stays 0.
- **Button reset:** in RUN, press for 20 cycles then release → `io_systemReset` rises at release+6, stays high exactly 8 cycles; cause=2; count=1. A second press/release during HOLD is ignored (count stays 1).
- **PLL loss:**
  - Drop `io_pllLocked` in RUN → reset rises on the 3rd edge; cause=1.
  - Restore lock mid-HOLD, then drop it again → FSM returns to WAIT_LOCK; `hold_cnt` restarts from 0 on relock.
  - Simultaneous PLL loss and release event → cause=1, count unchanged.
- **Saturation:** perform 256 button resets → `io_buttonResets`=255 after both the 255th and the 256th.
- **Async reset in HOLD:** pulse `io_asyncResetn` low for 1 ns mid-HOLD with count=5 → outputs immediately return to 1/0/0, the FSM restarts from WAIT_LOCK, and a full 8-cycle hold follows.
